// File: rtl/traffic_sensor_frontend.sv
// Sensor front end: synchronises and debounces vehicle loops and ambulance beacons,
// reports per-window vehicle densities and held ambulance requests for four approaches.
module traffic_sensor_frontend #(
   parameter int WINDOW   = 64,
   parameter int DEBOUNCE = 3,
   parameter int AMB_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_a,
   input  logic       veh_n,
   input  logic       veh_s,
   input  logic       veh_e,
   input  logic       veh_w,
   input  logic       amb_raw_n,
   input  logic       amb_raw_s,
   input  logic       amb_raw_e,
   input  logic       amb_raw_w,
   output logic [3:0] density_n,
   output logic [3:0] density_s,
   output logic [3:0] density_e,
   output logic [3:0] density_w,
   output logic       density_valid,
   output logic       amb_n,
   output logic       amb_s,
   output logic       amb_e,
   output logic       amb_w
);

   localparam int WW = $clog2(WINDOW);
   localparam logic [WW-1:0] W_LAST    = WW'(WINDOW - 1);
   localparam logic [3:0]    DB_LAST   = 4'(DEBOUNCE - 1);
   localparam logic [7:0]    HOLD_LOAD = 8'(AMB_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      HOLD   = 2'd2
   } amb_state_t;

   // Bits 3:0 are the vehicle loops n,s,e,w; bits 7:4 the ambulance beacons n,s,e,w.
   logic [7:0]    raw;
   logic [7:0]    sync_a;
   logic [7:0]    sync_b;
   logic [7:0]    filt;
   logic [3:0]    db_cnt [8];
   logic [3:0]    veh_d;
   logic [3:0]    veh_rise;
   logic [3:0]    veh_cnt [4];
   logic [3:0]    dens [4];
   logic [WW-1:0] win_cnt;
   logic          win_wrap;
   amb_state_t    amb_state [4];
   amb_state_t    amb_state_nx [4];
   logic [7:0]    hold_cnt [4];
   logic [7:0]    hold_nx [4];
   logic [3:0]    amb_q;

   assign raw = {amb_raw_w, amb_raw_e, amb_raw_s, amb_raw_n,
                 veh_w, veh_e, veh_s, veh_n};

   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
      end
   end

   // Filtered level follows the synchronised input only after DEBOUNCE consecutive disagreeing cycles.
   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         filt <= '0;
         for (int i = 0; i < 8; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (sync_b[i] == filt[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               filt[i]   <= sync_b[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 4'd1;
            end
         end
      end
   end

   assign veh_rise = filt[3:0] & ~veh_d;
   assign win_wrap = (win_cnt == W_LAST);

   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         veh_d   <= '0;
         win_cnt <= '0;
      end else begin
         veh_d   <= filt[3:0];
         win_cnt <= win_wrap ? '0 : win_cnt + WW'(1);
      end
   end

   // A rise seen on the wrap edge seeds the next window so nothing is lost at the boundary.
   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         density_valid <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            veh_cnt[i] <= '0;
            dens[i]    <= '0;
         end
      end else begin
         density_valid <= win_wrap;
         for (int i = 0; i < 4; i++) begin
            if (win_wrap) begin
               dens[i]    <= veh_cnt[i];
               veh_cnt[i] <= {3'b000, veh_rise[i]};
            end else if (veh_rise[i] && (veh_cnt[i] != 4'hF)) begin
               veh_cnt[i] <= veh_cnt[i] + 4'd1;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         amb_state_nx[i] = IDLE;
         hold_nx[i]      = hold_cnt[i];
         case (amb_state[i])
            IDLE: begin
               if (filt[4 + i]) begin
                  amb_state_nx[i] = ACTIVE;
               end
            end
            ACTIVE: begin
               if (filt[4 + i]) begin
                  amb_state_nx[i] = ACTIVE;
               end else begin
                  amb_state_nx[i] = HOLD;
                  hold_nx[i]      = HOLD_LOAD;
               end
            end
            HOLD: begin
               if (filt[4 + i]) begin
                  amb_state_nx[i] = ACTIVE;
               end else if (hold_cnt[i] == 8'd0) begin
                  amb_state_nx[i] = IDLE;
               end else begin
                  amb_state_nx[i] = HOLD;
                  hold_nx[i]      = hold_cnt[i] - 8'd1;
               end
            end
            default: begin
               amb_state_nx[i] = IDLE;
            end
         endcase
      end
   end

   // The request output is registered from the next state so it lines up with the state register.
   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         amb_q <= '0;
         for (int i = 0; i < 4; i++) begin
            amb_state[i] <= IDLE;
            hold_cnt[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            amb_state[i] <= amb_state_nx[i];
            hold_cnt[i]  <= hold_nx[i];
            amb_q[i]     <= (amb_state_nx[i] != IDLE);
         end
      end
   end

   assign density_n = dens[0];
   assign density_s = dens[1];
   assign density_e = dens[2];
   assign density_w = dens[3];
   assign amb_n     = amb_q[0];
   assign amb_s     = amb_q[1];
   assign amb_e     = amb_q[2];
   assign amb_w     = amb_q[3];

endmodule

// File: tb/tb_traffic_sensor_frontend.sv
// Bench for traffic_sensor_frontend: a sliding-history model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_traffic_sensor_frontend;

   // Window long enough to fit twenty minimum-width debounced pulses.
   localparam int WIN  = 128;
   localparam int DB   = 3;
   localparam int HOLD = 8;

   logic       clk = 1'b0;
   logic       rst_a;
   logic [7:0] raw_in;
   logic [3:0] density_n, density_s, density_e, density_w;
   logic       density_valid;
   logic       amb_n, amb_s, amb_e, amb_w;

   int         checks = 0;
   int         errors = 0;
   int         edge_no;
   logic       edge_rst = 1'b1;
   logic [7:0] edge_raw = '0;

   logic       rawh [8][16];
   logic       fh [8][16];
   int         ecount;
   int         mcount [4];
   int         exp_dens [4];
   logic       exp_dv;
   logic [3:0] exp_amb;

   always #5 clk = ~clk;

   traffic_sensor_frontend #(
      .WINDOW   (WIN),
      .DEBOUNCE (DB),
      .AMB_HOLD (HOLD)
   ) dut (
      .clk           (clk),
      .rst_a         (rst_a),
      .veh_n         (raw_in[0]),
      .veh_s         (raw_in[1]),
      .veh_e         (raw_in[2]),
      .veh_w         (raw_in[3]),
      .amb_raw_n     (raw_in[4]),
      .amb_raw_s     (raw_in[5]),
      .amb_raw_e     (raw_in[6]),
      .amb_raw_w     (raw_in[7]),
      .density_n     (density_n),
      .density_s     (density_s),
      .density_e     (density_e),
      .density_w     (density_w),
      .density_valid (density_valid),
      .amb_n         (amb_n),
      .amb_s         (amb_s),
      .amb_e         (amb_e),
      .amb_w         (amb_w)
   );

   always @(posedge clk or posedge rst_a) begin
      if (rst_a) edge_no <= 0;
      else       edge_no <= edge_no + 1;
   end

   always @(posedge clk) begin
      edge_rst <= rst_a;
      edge_raw <= raw_in;
   end

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0d, want %0d", name, $time, actual, expected);
      end
   endtask

   task automatic model_reset();
      ecount = 0;
      exp_dv = 1'b0;
      exp_amb = '0;
      for (int i = 0; i < 8; i++) begin
         for (int d = 0; d < 16; d++) begin
            rawh[i][d] = 1'b0;
            fh[i][d]   = 1'b0;
         end
      end
      for (int v = 0; v < 4; v++) begin
         mcount[v]   = 0;
         exp_dens[v] = 0;
      end
   endtask

   // Filtered level flips once the input seen two edges late has disagreed with it DB times in a row;
   // a vehicle counts one edge after its filtered rise; a request is up while filtered amb was high
   // at any point in the last HOLD+1 edges.
   task automatic model_step(input logic [7:0] r);
      logic flip;
      logic ev;
      logic any;
      ecount++;
      for (int i = 0; i < 8; i++) begin
         for (int d = 15; d >= 1; d--) rawh[i][d] = rawh[i][d-1];
         rawh[i][0] = r[i];
         flip = 1'b1;
         for (int d = 2; d <= DB + 1; d++) begin
            if (rawh[i][d] == fh[i][0]) flip = 1'b0;
         end
         for (int d = 15; d >= 1; d--) fh[i][d] = fh[i][d-1];
         fh[i][0] = flip ? ~fh[i][1] : fh[i][1];
      end
      exp_dv = ((ecount % WIN) == 0);
      for (int v = 0; v < 4; v++) begin
         ev = fh[v][1] & ~fh[v][2];
         if (exp_dv) begin
            exp_dens[v] = (mcount[v] > 15) ? 15 : mcount[v];
            mcount[v]   = ev ? 1 : 0;
         end else begin
            mcount[v] += ev ? 1 : 0;
         end
      end
      for (int a = 0; a < 4; a++) begin
         any = 1'b0;
         for (int d = 1; d <= HOLD + 1; d++) any = any | fh[4+a][d];
         exp_amb[a] = any;
      end
   endtask

   always @(negedge clk) begin
      if (rst_a)          model_reset();
      else if (!edge_rst) model_step(edge_raw);
      check_output("model_density_n", int'(density_n), exp_dens[0]);
      check_output("model_density_s", int'(density_s), exp_dens[1]);
      check_output("model_density_e", int'(density_e), exp_dens[2]);
      check_output("model_density_w", int'(density_w), exp_dens[3]);
      check_output("model_density_valid", int'(density_valid), int'(exp_dv));
      check_output("model_amb_n", int'(amb_n), int'(exp_amb[0]));
      check_output("model_amb_s", int'(amb_s), int'(exp_amb[1]));
      check_output("model_amb_e", int'(amb_e), int'(exp_amb[2]));
      check_output("model_amb_w", int'(amb_w), int'(exp_amb[3]));
   end

   task automatic wait_edge(input int n);
      while (edge_no < n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic after_edge(input int n);
      wait_edge(n);
      @(negedge clk);
   endtask

   // Raw input goes high just after edge 'start' and is sampled high on 'len' edges.
   task automatic apply_pulse(input int idx, input int start, input int len);
      wait_edge(start);
      raw_in[idx] = 1'b1;
      wait_edge(start + len);
      raw_in[idx] = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog at %0t: got 0, want 1", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int found;
      int first;
      rst_a  = 1'b1;
      raw_in = '0;
      @(negedge clk);
      @(negedge clk);
      check_output("reset_density_n", int'(density_n), 0);
      check_output("reset_density_valid", int'(density_valid), 0);
      check_output("reset_amb_s", int'(amb_s), 0);
      @(posedge clk);
      #2;
      rst_a = 1'b0;

      // Window 1: five clean north vehicles, east glitches, south ambulance with a cancelled hold
      for (int p = 0; p < 5; p++) apply_pulse(0, 4 + 8 * p, 4);
      apply_pulse(2, 50, 1);
      apply_pulse(2, 60, 2);
      wait_edge(70);
      raw_in[5] = 1'b1;
      after_edge(75);
      check_output("amb_s_before_rise", int'(amb_s), 0);
      after_edge(76);
      check_output("amb_s_rise", int'(amb_s), 1);
      wait_edge(80);
      raw_in[5] = 1'b0;
      after_edge(93);
      check_output("amb_s_hold_end", int'(amb_s), 1);
      after_edge(94);
      check_output("amb_s_fall", int'(amb_s), 0);
      apply_pulse(5, 100, 5);
      wait_edge(112);
      raw_in[5] = 1'b1;
      wait_edge(116);
      raw_in[5] = 1'b0;
      after_edge(119);
      check_output("amb_s_hold_cancel", int'(amb_s), 1);
      after_edge(127);
      check_output("dv_before_wrap", int'(density_valid), 0);
      after_edge(128);
      check_output("w1_density_n", int'(density_n), 5);
      check_output("w1_density_e", int'(density_e), 0);
      check_output("w1_density_s", int'(density_s), 0);
      check_output("w1_density_w", int'(density_w), 0);
      check_output("w1_dv", int'(density_valid), 1);
      after_edge(129);
      check_output("amb_s_still_held", int'(amb_s), 1);
      check_output("dv_one_cycle", int'(density_valid), 0);
      after_edge(130);
      check_output("amb_s_final_fall", int'(amb_s), 0);

      // Window 2: minimum-width east pulse, north vehicle counted on the wrap edge
      apply_pulse(2, 135, 3);
      apply_pulse(0, 250, 4);
      after_edge(256);
      check_output("w2_density_n", int'(density_n), 0);
      check_output("w2_density_e", int'(density_e), 1);
      check_output("w2_dv", int'(density_valid), 1);

      // Window 3: twenty west vehicles saturate
      for (int p = 0; p < 20; p++) apply_pulse(3, 260 + 6 * p, 3);
      after_edge(384);
      check_output("w3_density_w", int'(density_w), 15);
      check_output("w3_density_n", int'(density_n), 1);
      check_output("w3_density_e", int'(density_e), 0);

      // Window 4: west idle, three south vehicles
      for (int p = 0; p < 3; p++) apply_pulse(1, 400 + 8 * p, 4);
      after_edge(512);
      check_output("w4_density_w", int'(density_w), 0);
      check_output("w4_density_s", int'(density_s), 3);
      check_output("w4_density_n", int'(density_n), 0);

      // Window 5: seven north vehicles and a north ambulance in hold, then reset
      for (int p = 0; p < 7; p++) apply_pulse(0, 515 + 6 * p, 3);
      wait_edge(560);
      raw_in[4] = 1'b1;
      wait_edge(564);
      raw_in[4] = 1'b0;
      after_edge(572);
      check_output("pre_reset_amb_n", int'(amb_n), 1);
      check_output("pre_reset_density_s", int'(density_s), 3);
      #2;
      rst_a = 1'b1;
      #1;
      check_output("reset_now_density_s", int'(density_s), 0);
      check_output("reset_now_amb_n", int'(amb_n), 0);
      check_output("reset_now_dv", int'(density_valid), 0);
      repeat (3) @(posedge clk);
      #2;
      rst_a = 1'b0;
      found = 0;
      first = 0;
      for (int n = 1; n <= 2 * WIN && found == 0; n++) begin
         @(negedge clk);
         if (density_valid) begin
            found = 1;
            first = edge_no;
         end
      end
      check_output("dv_after_reset_edge", first, WIN);
      check_output("post_reset_density_n", int'(density_n), 0);
      check_output("post_reset_amb_n", int'(amb_n), 0);
      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
